// File: rtl/boolean_sweep_ctrl_if.sv
// rtl/boolean_sweep_ctrl_if.sv - host and evaluator signals of the boolean sweep controller
interface boolean_sweep_ctrl_if;
  logic        start;
  logic [3:0]  settle_cycles;
  logic [31:0] expected;
  logic [4:0]  eval_in;
  logic        eval_y;
  logic        busy;
  logic        done;
  logic [31:0] truth_table;
  logic [5:0]  mismatch_cnt;
  logic        pass;

  modport master (
    output start, settle_cycles, expected, eval_y,
    input  eval_in, busy, done, truth_table, mismatch_cnt, pass
  );

  modport slave (
    input  start, settle_cycles, expected, eval_y,
    output eval_in, busy, done, truth_table, mismatch_cnt, pass
  );
endinterface

// File: rtl/boolean_sweep_ctrl.sv
// rtl/boolean_sweep_ctrl.sv - sweeps all 32 inputs of a 5-input evaluator and scores it against a golden table
module boolean_sweep_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  boolean_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  eval_in_q, eval_in_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  s_q, s_d;
  logic [31:0] e_q, e_d;
  logic [31:0] tt_q, tt_d;
  logic [5:0]  mc_q, mc_d;
  logic        pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      eval_in_q <= 5'd0;
      cnt_q     <= 4'd0;
      s_q       <= 4'd0;
      e_q       <= 32'd0;
      tt_q      <= 32'd0;
      mc_q      <= 6'd0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      eval_in_q <= eval_in_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      e_q       <= e_d;
      tt_q      <= tt_d;
      mc_q      <= mc_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    eval_in_d = eval_in_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    e_d       = e_q;
    tt_d      = tt_q;
    mc_d      = mc_q;
    pass_d    = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d       = bus.settle_cycles;
          e_d       = bus.expected;
          eval_in_d = 5'd0;
          tt_d      = 32'd0;
          mc_d      = 6'd0;
          pass_d    = 1'b0;
          cnt_d     = bus.settle_cycles;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        tt_d[eval_in_q] = bus.eval_y;
        // At most 32 increments per sweep, so the 6-bit count never wraps.
        if (bus.eval_y != e_q[eval_in_q]) mc_d = mc_q + 6'd1;
        if (eval_in_q == 5'd31) begin
          state_d = DONE;
        end else begin
          eval_in_d = eval_in_q + 5'd1;
          cnt_d     = s_q;
          state_d   = SETTLE;
        end
      end
      DONE: begin
        pass_d  = (mc_q == 6'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.eval_in      = eval_in_q;
  assign bus.busy         = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done         = (state_q == DONE);
  assign bus.truth_table  = tt_q;
  assign bus.mismatch_cnt = mc_q;
  assign bus.pass         = pass_q;

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// tb/tb_boolean_sweep_ctrl.sv - directed bench for boolean_sweep_ctrl
module tb_boolean_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic tied_one;
  int   tests = 0;
  int   fails = 0;

  boolean_sweep_ctrl_if intf ();

  boolean_sweep_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  always #5 clk = ~clk;

  // Reference evaluator Y = A|B|C, or a stuck-at-1 output.
  assign intf.eval_y = tied_one ? 1'b1 : (intf.eval_in[4] | intf.eval_in[3] | intf.eval_in[2]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic do_start(input logic [3:0] s, input logic [31:0] e);
    intf.start         = 1'b1;
    intf.settle_cycles = s;
    intf.expected      = e;
    @(posedge clk);
    #1 intf.start = 1'b0;
  endtask

  // Returns the number of edges after the start-accept edge at which done is seen.
  task automatic wait_done(input int limit, input bit disturb, output int lat);
    lat = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("eval_in_first", 64'(intf.eval_in), 64'd0);
        check("busy_first", 64'(intf.busy), 64'd1);
      end
      if (disturb && k == 10) begin
        intf.start         = 1'b1;
        intf.settle_cycles = 4'd7;
        intf.expected      = 32'h0;
      end
      if (disturb && k == 12) intf.start = 1'b0;
      if (intf.done) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    int lat;
    bit found;
    int dpos[$];

    rst                = 1'b1;
    tied_one           = 1'b0;
    intf.start         = 1'b0;
    intf.settle_cycles = 4'd0;
    intf.expected      = 32'h0;
    repeat (3) @(posedge clk);
    intf.start = 1'b1;
    @(negedge clk);
    check("rst_eval_in", 64'(intf.eval_in), 64'd0);
    check("rst_busy", 64'(intf.busy), 64'd0);
    check("rst_done", 64'(intf.done), 64'd0);
    check("rst_tt", 64'(intf.truth_table), 64'd0);
    check("rst_mc", 64'(intf.mismatch_cnt), 64'd0);
    check("rst_pass", 64'(intf.pass), 64'd0);
    rst = 1'b0;

    // S=0, matching golden table; accepted on the first edge after reset.
    do_start(4'd0, 32'hFFFFFFF0);
    wait_done(200, 1'b0, lat);
    check("s0_latency", 64'(lat), 64'd64);
    @(negedge clk);
    check("s0_done_pulse", 64'(intf.done), 64'd0);
    check("s0_tt", 64'(intf.truth_table), 64'hFFFFFFF0);
    check("s0_mc", 64'(intf.mismatch_cnt), 64'd0);
    check("s0_pass", 64'(intf.pass), 64'd1);
    repeat (5) @(negedge clk);
    check("s0_hold_tt", 64'(intf.truth_table), 64'hFFFFFFF0);
    check("s0_hold_pass", 64'(intf.pass), 64'd1);

    // S=3, golden all ones: four mismatches.
    do_start(4'd3, 32'hFFFFFFFF);
    wait_done(400, 1'b0, lat);
    check("s3_latency", 64'(lat), 64'd160);
    @(negedge clk);
    check("s3_tt", 64'(intf.truth_table), 64'hFFFFFFF0);
    check("s3_mc", 64'(intf.mismatch_cnt), 64'd4);
    check("s3_pass", 64'(intf.pass), 64'd0);

    // Stuck-at-1 evaluator against all-zero golden table: 32 mismatches.
    tied_one = 1'b1;
    do_start(4'd0, 32'h0);
    wait_done(200, 1'b0, lat);
    check("all_latency", 64'(lat), 64'd64);
    @(negedge clk);
    check("all_mc", 64'(intf.mismatch_cnt), 64'd32);
    check("all_tt", 64'(intf.truth_table), 64'hFFFFFFFF);
    check("all_pass", 64'(intf.pass), 64'd0);
    tied_one = 1'b0;

    // Abort mid-sweep at vector 17.
    do_start(4'd0, 32'hFFFFFFF0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (intf.eval_in == 5'd17) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_17", 64'(found), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_eval_in", 64'(intf.eval_in), 64'd0);
    check("abort_busy", 64'(intf.busy), 64'd0);
    check("abort_done", 64'(intf.done), 64'd0);
    check("abort_tt", 64'(intf.truth_table), 64'd0);
    check("abort_mc", 64'(intf.mismatch_cnt), 64'd0);
    do_start(4'd0, 32'hFFFFFFF0);
    wait_done(200, 1'b0, lat);
    check("fresh_latency", 64'(lat), 64'd64);
    @(negedge clk);
    check("fresh_pass", 64'(intf.pass), 64'd1);

    // Disturbed sweep: start pulse and input changes mid-sweep, start during DONE.
    do_start(4'd1, 32'hFFFFFFF0);
    wait_done(300, 1'b1, lat);
    check("dist_latency", 64'(lat), 64'd96);
    intf.start = 1'b1;
    @(posedge clk);
    #1 intf.start = 1'b0;
    @(negedge clk);
    check("dist_done_pulse", 64'(intf.done), 64'd0);
    check("dist_busy_after", 64'(intf.busy), 64'd0);
    @(negedge clk);
    check("dist_no_queue", 64'(intf.busy), 64'd0);
    check("dist_tt", 64'(intf.truth_table), 64'hFFFFFFF0);
    check("dist_mc", 64'(intf.mismatch_cnt), 64'd0);
    check("dist_pass", 64'(intf.pass), 64'd1);

    // start held for back-to-back sweeps with S=1.
    intf.start         = 1'b1;
    intf.settle_cycles = 4'd1;
    intf.expected      = 32'hFFFFFFF0;
    @(posedge clk);
    for (int k = 0; k <= 300; k++) begin
      @(negedge clk);
      if (intf.done) dpos.push_back(k);
      if (dpos.size() > 0 && k == dpos[$] + 2)
        check("held_restart_eval_in", 64'(intf.eval_in), 64'd0);
      @(posedge clk);
    end
    intf.start = 1'b0;
    check("held_done_count", 64'(dpos.size()), 64'd3);
    if (dpos.size() == 3) begin
      check("held_first", 64'(dpos[0]), 64'd96);
      check("held_gap1", 64'(dpos[1] - dpos[0]), 64'd98);
      check("held_gap2", 64'(dpos[2] - dpos[1]), 64'd98);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
